// File: rtl/trace_sink_arbiter.sv
// trace_sink_arbiter: round-robin arbiter that lets the per-stage trace
// trackers (IF, ID, EX, ...) share one trace sink write port. The granted
// record is registered into a single output slot together with its source
// index and, optionally, the cycle timestamp of acceptance.
//
// Optional feature macro: TRACE_ARB_TIMESTAMP_EN
//   defined   -> free-running TS_WIDTH cycle counter, sink_ts = counter value
//                in the handshake cycle
//   undefined -> no counter, sink_ts tied to 0
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. A source must hold valid and data
// stable until it is accepted. Ready may depend combinationally on valid
// (src_ready is derived from src_valid and sink_ready), and a record is
// never dropped or duplicated except on reset, which discards the slot.
//
// dbg_state (1 = slot FULL) and dbg_rr_ptr expose the internal state.
module trace_sink_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int TRACE_WIDTH = 64,
    parameter int TS_WIDTH    = 32,
    localparam int SRC_ID_WIDTH = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*TRACE_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]             src_ready,
    output logic                           sink_valid,
    output logic [TRACE_WIDTH-1:0]         sink_data,
    output logic [SRC_ID_WIDTH-1:0]        sink_src_id,
    output logic [TS_WIDTH-1:0]            sink_ts,
    input  logic                           sink_ready,
    output logic [15:0]                    grant_count,
    output logic                           dbg_state,
    output logic [SRC_ID_WIDTH-1:0]        dbg_rr_ptr
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    slot_state_e             state_q, state_d;
    logic [SRC_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]             grant_count_q, grant_count_d;
    logic [TRACE_WIDTH-1:0]  data_q;
    logic [SRC_ID_WIDTH-1:0] src_id_q;

    logic                    slot_free;
    logic                    grant_found;
    logic [SRC_ID_WIDTH-1:0] grant_idx;
    logic                    grant_fire;
    logic [TRACE_WIDTH-1:0]  sel_data;

    // Rotating-priority search: the first valid source at or after rr_ptr wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_SRC;
            if (!grant_found && src_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_ID_WIDTH'(idx);
            end
        end
    end

    // A grant only fires out of reset and when the slot can take a record.
    assign grant_fire = rst && slot_free && grant_found;

    // Record of the winning source, picked from the flat data bus.
    always_comb begin
        sel_data = src_data[int'(grant_idx)*TRACE_WIDTH +: TRACE_WIDTH];
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: fill on grant, drain when the sink takes the record
    // and no replacement is granted in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (grant_fire) state_d = S_FULL;
            S_FULL:  if (sink_ready && !grant_fire) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    // Slot outputs: occupancy, free indication and the one-hot accept.
    always_comb begin
        sink_valid = (state_q == S_FULL);
        slot_free  = (state_q == S_EMPTY) || sink_ready;
        dbg_state  = (state_q == S_FULL);
        src_ready  = '0;
        if (grant_fire) begin
            src_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer advance and saturating grant counter on every handshake.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        grant_count_d = grant_count_q;
        if (grant_fire) begin
            if (grant_idx == SRC_ID_WIDTH'(NUM_SRC - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + SRC_ID_WIDTH'(1);
            end
            if (grant_count_q != 16'hFFFF) begin
                grant_count_d = grant_count_q + 16'd1;
            end
        end
    end

    // Arbitration bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q      <= '0;
            grant_count_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            grant_count_q <= grant_count_d;
        end
    end

    // Output slot payload: loaded on handshake, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q   <= '0;
            src_id_q <= '0;
        end else if (grant_fire) begin
            data_q   <= sel_data;
            src_id_q <= grant_idx;
        end
    end

`ifdef TRACE_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_q;
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running cycle counter; wraps naturally at 2^TS_WIDTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
        end
    end

    // Timestamp captured alongside the record in the handshake cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q <= '0;
        end else if (grant_fire) begin
            ts_q <= ts_cnt_q;
        end
    end

    assign sink_ts = ts_q;
`else
    assign sink_ts = '0;
`endif

    assign sink_data   = data_q;
    assign sink_src_id = src_id_q;
    assign grant_count = grant_count_q;
    assign dbg_rr_ptr  = rr_ptr_q;

endmodule
